// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

    // Clear-sweep controller states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Number of entries addressed by an addr_w-bit address
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: walks a pointer over every entry, zeroing one per
// cycle, and reports progress through registered busy / clr_done flags.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output clr_state_t        state
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    clr_state_t        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic              busy_d;
    logic              done_d;

    // State, pointer and the registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr_q    <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_d;
            ptr_q    <= ptr_d;
            busy     <= busy_d;
            clr_done <= done_d;
        end
    end

    // Next state: clr_req is only honoured in IDLE, so a request held through
    // clr_done starts the next sweep on the edge that ends the clr_done cycle.
    always_comb begin
        state_d = state;
        ptr_d   = ptr_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                ptr_d  = ptr_q + 1'b1;
                busy_d = 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign clear_we   = (state == CLEAR);
    assign clear_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// 2^ADDR_W x DATA_W register file: two combinational read ports, one
// synchronous write port, optional write bypass, optional zero entry, and a
// sequential clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clear_we;
    logic [ADDR_W-1:0] clear_addr;
    clr_state_t        fsm_state;
    logic              wr_ok;

    regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .busy       (busy),
        .clr_done   (clr_done),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .state      (fsm_state)
    );

    // A user write counts only while idle and not aimed at a hard-wired zero
    always_comb begin
        wr_ok = we && (fsm_state == IDLE);
        if ((ZERO_REG != 0) && (waddr == '0))
            wr_ok = 1'b0;
    end

    // Array storage: sweep writes take priority over (ignored) user writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: array, then bypass, then zero-entry override
    always_comb begin
        rdata1 = mem[raddr1];
        rdata2 = mem[raddr2];
        if ((BYPASS != 0) && wr_ok && (raddr1 == waddr))
            rdata1 = wdata;
        if ((BYPASS != 0) && wr_ok && (raddr2 == waddr))
            rdata2 = wdata;
        if ((ZERO_REG != 0) && (raddr1 == '0))
            rdata1 = '0;
        if ((ZERO_REG != 0) && (raddr2 == '0))
            rdata2 = '0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (bypass, no bypass, zero
// entry) share stimulus; expectations are queued and checked each negedge.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  raddr1 = '0;
    logic [1:0]  raddr2 = '0;
    logic        clr_req = 1'b0;

    logic [31:0] m_r1, m_r2, nb_r1, nb_r2, z_r1, z_r2;
    logic        m_busy, m_done, nb_busy, nb_done, z_busy, z_done;

    // Signal ids used in expectations
    localparam int S_M_R1 = 0, S_M_R2 = 1, S_NB_R1 = 2, S_Z_R1 = 3, S_BUSY = 4, S_DONE = 5;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(2), .BYPASS(1), .ZERO_REG(0)) u_main (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(m_r1), .rdata2(m_r2),
        .clr_req(clr_req), .busy(m_busy), .clr_done(m_done)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(2), .BYPASS(0), .ZERO_REG(0)) u_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_r1), .rdata2(nb_r2),
        .clr_req(clr_req), .busy(nb_busy), .clr_done(nb_done)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(2), .BYPASS(1), .ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_r1), .rdata2(z_r2),
        .clr_req(clr_req), .busy(z_busy), .clr_done(z_done)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            S_M_R1:  return m_r1;
            S_M_R2:  return m_r2;
            S_NB_R1: return nb_r1;
            S_Z_R1:  return z_r1;
            S_BUSY:  return {31'b0, m_busy};
            S_DONE:  return {31'b0, m_done};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Scoreboard monitor: compares everything queued for this cycle
    initial begin
        exp_t e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = obs(e.sig);
                n_checks++;
                if (got !== e.val) begin
                    n_fails++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, got, e.val, $time);
                end
            end
        end
    end

    task automatic push(input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.sig = sig; e.val = val; e.name = name;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] wa, input logic [31:0] wd,
                         input logic [1:0] r1, input logic [1:0] r2, input logic c);
        we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2; clr_req = c;
    endtask

    initial begin
        // Reset asserted between edges; read every address while it is held
        #2 rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            drive(0, 2'd0, 32'h0, 2'(a), 2'(3 - a), 0);
            push(S_M_R1, 32'h0, "reset_rd1");
            push(S_M_R2, 32'h0, "reset_rd2");
            push(S_BUSY, 32'h0, "reset_busy");
            push(S_DONE, 32'h0, "reset_done");
            cyc();
        end
        rst = 1'b0;

        // Writes to addr 2 and 3, read back the next cycle
        drive(1, 2'd2, 32'hDEADBEEF, 2'd0, 2'd0, 0);
        cyc();
        drive(1, 2'd3, 32'h12345678, 2'd2, 2'd2, 0);
        push(S_M_R1, 32'hDEADBEEF, "wr2_rd1");
        push(S_M_R2, 32'hDEADBEEF, "wr2_rd2");
        push(S_NB_R1, 32'hDEADBEEF, "wr2_nb");
        cyc();
        drive(0, 2'd0, 32'h0, 2'd2, 2'd3, 0);
        push(S_M_R1, 32'hDEADBEEF, "rd_addr2");
        push(S_M_R2, 32'h12345678, "rd_addr3");
        cyc();

        // Bypass on port 1 only; no-bypass instance still shows old value
        drive(1, 2'd1, 32'hA5A5A5A5, 2'd1, 2'd3, 0);
        push(S_M_R1, 32'hA5A5A5A5, "bypass_rd1");
        push(S_M_R2, 32'h12345678, "bypass_rd2_other");
        push(S_NB_R1, 32'h00000000, "nobypass_old");
        push(S_Z_R1, 32'hA5A5A5A5, "zreg_bypass_nonzero");
        cyc();
        drive(0, 2'd0, 32'h0, 2'd1, 2'd3, 0);
        push(S_NB_R1, 32'hA5A5A5A5, "nobypass_after");
        cyc();

        // Writes to entry 0 are discarded (and not bypassed) with a zero entry
        drive(1, 2'd0, 32'hFFFFFFFF, 2'd0, 2'd0, 0);
        push(S_Z_R1, 32'h0, "zreg_no_bypass");
        push(S_M_R1, 32'hFFFFFFFF, "addr0_bypass");
        cyc();
        drive(0, 2'd0, 32'h0, 2'd0, 2'd0, 0);
        push(S_Z_R1, 32'h0, "zreg_stays0");
        push(S_NB_R1, 32'hFFFFFFFF, "addr0_written");
        cyc();

        // Fill, then sweep; writes during busy must vanish
        for (int a = 0; a < 4; a++) begin
            drive(1, 2'(a), 32'h11 * (a + 1), 2'd0, 2'd0, 0);
            cyc();
        end
        drive(0, 2'd0, 32'h0, 2'd0, 2'd3, 1);
        push(S_BUSY, 32'h0, "sweep_req_busy");
        push(S_M_R1, 32'h11, "fill_addr0");
        push(S_M_R2, 32'h44, "fill_addr3");
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'd3, 32'h00000BAD, (k == 0) ? 2'd0 : 2'(k - 1), 2'd3, 0);
            push(S_BUSY, 32'h1, "sweep_busy");
            push(S_DONE, 32'h0, "sweep_no_done");
            push(S_M_R1, (k == 0) ? 32'h11 : 32'h0, "sweep_progress");
            push(S_M_R2, 32'h44, "sweep_we_ignored");
            cyc();
        end
        drive(0, 2'd0, 32'h0, 2'd3, 2'd1, 0);
        push(S_BUSY, 32'h0, "sweep_end_busy");
        push(S_DONE, 32'h1, "sweep_done");
        push(S_M_R1, 32'h0, "swept_addr3");
        push(S_M_R2, 32'h0, "swept_addr1");
        cyc();
        push(S_DONE, 32'h0, "done_one_pulse");
        push(S_BUSY, 32'h0, "idle_after_sweep");
        cyc();

        // Write and clr_req in the same cycle; clr_req held through clr_done
        drive(1, 2'd3, 32'h77, 2'd3, 2'd0, 1);
        push(S_M_R1, 32'h77, "simul_bypass");
        push(S_BUSY, 32'h0, "simul_busy0");
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(0, 2'd0, 32'h0, 2'd3, 2'd0, 1);
            push(S_BUSY, 32'h1, "simul_busy");
            push(S_M_R1, (k < 3) ? 32'h77 : 32'h77, "simul_write_kept");
            cyc();
        end
        push(S_BUSY, 32'h0, "held_done_busy");
        push(S_DONE, 32'h1, "held_done");
        push(S_M_R1, 32'h0, "simul_addr3_cleared");
        cyc();
        push(S_BUSY, 32'h1, "second_sweep_busy");
        push(S_DONE, 32'h0, "second_sweep_done0");
        clr_req = 1'b0;
        cyc();
        for (int k = 1; k < 4; k++) begin
            push(S_BUSY, 32'h1, "second_sweep_len");
            cyc();
        end
        push(S_DONE, 32'h1, "second_done");
        cyc();

        // Reset during the second busy cycle
        drive(1, 2'd3, 32'h99, 2'd0, 2'd0, 0);
        cyc();
        drive(1, 2'd2, 32'h88, 2'd0, 2'd0, 0);
        cyc();
        drive(0, 2'd0, 32'h0, 2'd3, 2'd2, 1);
        push(S_M_R1, 32'h99, "pre_rst_addr3");
        push(S_M_R2, 32'h88, "pre_rst_addr2");
        cyc();
        clr_req = 1'b0;
        push(S_BUSY, 32'h1, "rst_busy_c0");
        cyc();
        #1 rst = 1'b1;
        push(S_BUSY, 32'h0, "rst_busy_drop");
        push(S_DONE, 32'h0, "rst_no_done");
        push(S_M_R1, 32'h0, "rst_addr3_zero");
        push(S_M_R2, 32'h0, "rst_addr2_zero");
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(S_DONE, 32'h0, "post_rst_no_done");
            push(S_BUSY, 32'h0, "post_rst_idle");
            cyc();
        end

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
